// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store controller: op codes,
// memory strobe constants, FSM state type and small decode helpers.
package mem_access_unit_pkg;

   localparam int DEF_MEM_AW = 12;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LW  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LB  = 4'd4;
   localparam logic [3:0] OP_LBU = 4'd5;
   localparam logic [3:0] OP_SW  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SB  = 4'd8;

   localparam logic RamEnable  = 1'b1;
   localparam logic RamDisable = 1'b0;
   localparam logic RamWrite   = 1'b1;
   localparam logic RamRead    = 1'b0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WR   = 1'b1
   } state_e;

   function automatic logic is_load(input logic [3:0] op);
      return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
             (op == OP_LB) || (op == OP_LBU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

   // Word ops need a 4-byte boundary, half ops a 2-byte one; bytes always fit.
   function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] off);
      logic ok;
      case (op)
         OP_LW, OP_SW:         ok = (off == 2'b00);
         OP_LH, OP_LHU, OP_SH: ok = (off[0] == 1'b0);
         default:              ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_access_unit_lsu_byte_lane.sv
// Byte-lane datapath: picks the addressed byte/half out of a memory word and
// extends it for loads, and builds the read-modify-write word for sub-word stores.
module lsu_byte_lane
   import mem_access_unit_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rdata_i,
   input  logic [15:0] st_data_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select the addressed little-endian byte and half from the read word.
   always_comb begin
      byte_sel = rdata_i[7:0];
      case (off_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
      half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Sign- or zero-extend the selected lane according to the load op.
   always_comb begin
      ld_data_o = 32'h0;
      case (op_i)
         OP_LW:  ld_data_o = rdata_i;
         OP_LH:  ld_data_o = {{16{half_sel[15]}}, half_sel};
         OP_LHU: ld_data_o = {16'h0, half_sel};
         OP_LB:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU: ld_data_o = {24'h0, byte_sel};
         default: ld_data_o = 32'h0;
      endcase
   end

   // Replace only the addressed lane of the old word with the store data.
   always_comb begin
      merged_o = rdata_i;
      case (op_i)
         OP_SB: begin
            case (off_i)
               2'd0: merged_o[7:0]   = st_data_i[7:0];
               2'd1: merged_o[15:8]  = st_data_i[7:0];
               2'd2: merged_o[23:16] = st_data_i[7:0];
               2'd3: merged_o[31:24] = st_data_i[7:0];
               default: merged_o = rdata_i;
            endcase
         end
         OP_SH: begin
            if (off_i[1]) merged_o[31:16] = st_data_i;
            else          merged_o[15:0]  = st_data_i;
         end
         default: merged_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller. Maps word/half/byte ops onto a word-wide
// memory, extends load data, raises misalign/range faults, and performs
// sub-word stores as read (IDLE) then write (WR) with a one-cycle stall.
// Handshake: req_valid qualifies req_* each cycle; while stall=1 the request
// is ignored and upstream must keep presenting it until stall drops.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int MEM_AW = DEF_MEM_AW
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        exc_misalign,
   output logic        exc_range,
   output logic [31:0] exc_addr,
   output state_e      dbg_state
);

   state_e      state_q;
   logic [31:0] wr_addr_q;
   logic [31:0] wr_data_q;
   logic        ld_valid_q;
   logic [31:0] ld_data_q;
   logic        exc_misalign_q;
   logic        exc_range_q;
   logic [31:0] exc_addr_q;

   logic [31:0] ld_data_d;
   logic [31:0] wr_data_d;
   logic        accept;
   logic        aligned;
   logic        in_range;
   logic        fault_mis;
   logic        fault_rng;
   logic        legal;

   lsu_byte_lane u_lane (
      .op_i      (req_op),
      .off_i     (req_addr[1:0]),
      .rdata_i   (mem_rdata),
      .st_data_i (req_wdata[15:0]),
      .ld_data_o (ld_data_d),
      .merged_o  (wr_data_d)
   );

   // Classify the incoming request; only real memory ops in IDLE are considered.
   always_comb begin
      accept    = (state_q == ST_IDLE) && req_valid &&
                  (is_load(req_op) || is_store(req_op));
      aligned   = is_aligned(req_op, req_addr[1:0]);
      in_range  = (req_addr[31:MEM_AW] == '0);
      fault_mis = accept && !aligned;
      fault_rng = accept && aligned && !in_range;
      legal     = accept && aligned && in_range;
   end

   // Drive the memory port: WR replays the merged word, IDLE serves legal ops.
   always_comb begin
      mem_ce    = RamDisable;
      mem_we    = RamRead;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if (state_q == ST_WR) begin
         mem_ce    = RamEnable;
         mem_we    = RamWrite;
         mem_addr  = wr_addr_q;
         mem_wdata = wr_data_q;
      end else if (legal) begin
         mem_ce   = RamEnable;
         mem_addr = {req_addr[31:2], 2'b00};
         if (req_op == OP_SW) begin
            mem_we    = RamWrite;
            mem_wdata = req_wdata;
         end
      end
   end

   // FSM with registered load result, fault pulses and captured store word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         wr_addr_q      <= 32'h0;
         wr_data_q      <= 32'h0;
         ld_valid_q     <= 1'b0;
         ld_data_q      <= 32'h0;
         exc_misalign_q <= 1'b0;
         exc_range_q    <= 1'b0;
         exc_addr_q     <= 32'h0;
      end else begin
         ld_valid_q     <= 1'b0;
         exc_misalign_q <= 1'b0;
         exc_range_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fault_mis) begin
                  exc_misalign_q <= 1'b1;
                  exc_addr_q     <= req_addr;
               end else if (fault_rng) begin
                  exc_range_q <= 1'b1;
                  exc_addr_q  <= req_addr;
               end else if (legal) begin
                  if (is_load(req_op)) begin
                     ld_valid_q <= 1'b1;
                     ld_data_q  <= ld_data_d;
                  end else if ((req_op == OP_SB) || (req_op == OP_SH)) begin
                     wr_addr_q <= {req_addr[31:2], 2'b00};
                     wr_data_q <= wr_data_d;
                     state_q   <= ST_WR;
                  end
               end
            end
            ST_WR: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign stall        = (state_q == ST_WR);
   assign ld_valid     = ld_valid_q;
   assign ld_data      = ld_data_q;
   assign exc_misalign = exc_misalign_q;
   assign exc_range    = exc_range_q;
   assign exc_addr     = exc_addr_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a word memory driven by the DUT, plus a
// reference memory and load/merge model computed with plain arithmetic.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        mem_ce;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        exc_misalign;
   logic        exc_range;
   logic [31:0] exc_addr;
   state_e      dbg_state;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_ld_data  = 32'h0;
   logic [31:0] exp_exc_addr = 32'h0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   logic [31:0] pend_data = 32'h0;

   mem_access_unit #(.MEM_AW(12)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .stall        (stall),
      .mem_ce       (mem_ce),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .ld_valid     (ld_valid),
      .ld_data      (ld_data),
      .exc_misalign (exc_misalign),
      .exc_range    (exc_range),
      .exc_addr     (exc_addr),
      .dbg_state    (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, write on the rising edge
   assign mem_rdata = mem[mem_addr[11:2]];
   always @(posedge clk) begin
      if (mem_ce && mem_we) mem[mem_addr[11:2]] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr);
      logic [31:0] word, sh, v;
      word = ref_mem[addr[11:2]];
      sh   = word >> {addr[1:0], 3'b000};
      v    = 32'h0;
      if (op == OP_LW) v = word;
      else if (op == OP_LH || op == OP_LHU) begin
         v = sh & 32'h0000FFFF;
         if (op == OP_LH && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else begin
         v = sh & 32'h000000FF;
         if (op == OP_LB && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_merge(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] wd);
      logic [31:0] word, mask;
      word = ref_mem[addr[11:2]];
      mask = ((op == OP_SB) ? 32'h000000FF : 32'h0000FFFF) << {addr[1:0], 3'b000};
      return (word & ~mask) | ((wd << {addr[1:0], 3'b000}) & mask);
   endfunction

   // Called just after a falling edge: checks an outstanding write cycle, if any.
   task automatic wr_phase();
      if (pend) begin
         #1;
         chk("wr_stall", 32'(stall), 32'd1);
         chk("wr_ce", 32'(mem_ce), 32'd1);
         chk("wr_we", 32'(mem_we), 32'd1);
         chk("wr_addr", mem_addr, pend_addr);
         chk("wr_wdata", mem_wdata, pend_data);
         ref_mem[pend_addr[11:2]] = pend_data;
         pend = 1'b0;
         @(negedge clk);
         chk("wr_no_ld", 32'(ld_valid), 32'd0);
      end
      #1;
      chk("stall_clear", 32'(stall), 32'd0);
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
      logic        is_ld, is_st, mis, rng, ok;
      logic [31:0] sz;
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      wr_phase();
      is_ld = (op >= OP_LW) && (op <= OP_LBU);
      is_st = (op >= OP_SW) && (op <= OP_SB);
      sz    = (op == OP_LW || op == OP_SW) ? 32'd4 :
              (op == OP_LH || op == OP_LHU || op == OP_SH) ? 32'd2 : 32'd1;
      mis   = (is_ld || is_st) && ((addr % sz) != 32'd0);
      rng   = (is_ld || is_st) && !mis && ((addr >> 12) != 32'd0);
      ok    = (is_ld || is_st) && !mis && !rng;
      chk("mem_ce", 32'(mem_ce), 32'(ok));
      if (ok) begin
         chk("mem_we", 32'(mem_we), 32'(op == OP_SW));
         chk("mem_addr", mem_addr, addr & ~32'h3);
         if (op == OP_SW) chk("mem_wdata", mem_wdata, wd);
      end
      if (ok && is_ld) exp_ld_data = model_load(op, addr);
      if (ok && op == OP_SW) ref_mem[addr[11:2]] = wd;
      if (ok && (op == OP_SB || op == OP_SH)) begin
         pend      = 1'b1;
         pend_addr = addr & ~32'h3;
         pend_data = model_merge(op, addr, wd);
      end
      if (mis || rng) exp_exc_addr = addr;
      @(posedge clk);
      #1;
      chk("ld_valid", 32'(ld_valid), 32'(ok && is_ld));
      chk("ld_data", ld_data, exp_ld_data);
      chk("exc_misalign", 32'(exc_misalign), 32'(mis));
      chk("exc_range", 32'(exc_range), 32'(rng));
      chk("exc_addr", exc_addr, exp_exc_addr);
      chk("stall_after", 32'(stall), 32'(pend));
      @(negedge clk);
      req_valid = 1'b0; req_op = OP_NOP; req_addr = 32'h0; req_wdata = 32'h0;
   endtask

   task automatic idle_cycle();
      req_valid = 1'b0; req_op = OP_NOP; req_addr = 32'h0; req_wdata = 32'h0;
      wr_phase();
      chk("idle_ce", 32'(mem_ce), 32'd0);
      chk("idle_we", 32'(mem_we), 32'd0);
      chk("idle_addr", mem_addr, 32'h0);
      chk("idle_wdata", mem_wdata, 32'h0);
      @(posedge clk);
      #1;
      chk("idle_ld_valid", 32'(ld_valid), 32'd0);
      chk("idle_mis", 32'(exc_misalign), 32'd0);
      chk("idle_rng", 32'(exc_range), 32'd0);
      chk("idle_ld_data", ld_data, exp_ld_data);
      chk("idle_exc_addr", exc_addr, exp_exc_addr);
      @(negedge clk);
   endtask

   task automatic check_word(input logic [31:0] addr);
      chk("mem_word", mem[addr[11:2]], ref_mem[addr[11:2]]);
   endtask

   initial begin
      logic [3:0]  r_op;
      logic [31:0] r_addr;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      req_valid = 1'b0; req_op = OP_NOP; req_addr = 32'h0; req_wdata = 32'h0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_ce", 32'(mem_ce), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_ld_valid", 32'(ld_valid), 32'd0);
      chk("rst_ld_data", ld_data, 32'h0);
      chk("rst_mis", 32'(exc_misalign), 32'd0);
      chk("rst_rng", 32'(exc_range), 32'd0);
      chk("rst_exc_addr", exc_addr, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Preload the low 64 words with random data through the DUT
      for (int i = 0; i < 64; i++) issue(OP_SW, 32'(i * 4), $urandom);

      // Word store then load
      issue(OP_SW, 32'h10, 32'hDEADBEEF);
      issue(OP_LW, 32'h10, 32'h0);
      chk("lw_direct", ld_data, 32'hDEADBEEF);

      // Sub-word loads with extension
      issue(OP_SW, 32'h10, 32'h8899AABB);
      issue(OP_LB, 32'h11, 32'h0);
      chk("lb_direct", ld_data, 32'hFFFFFFAA);
      issue(OP_LBU, 32'h11, 32'h0);
      chk("lbu_direct", ld_data, 32'h000000AA);
      issue(OP_LH, 32'h12, 32'h0);
      chk("lh_direct", ld_data, 32'hFFFF8899);
      issue(OP_LHU, 32'h12, 32'h0);
      chk("lhu_direct", ld_data, 32'h00008899);

      // Sub-word stores via read-modify-write
      issue(OP_SW, 32'h20, 32'h11223344);
      issue(OP_SB, 32'h22, 32'h00000055);
      idle_cycle();
      chk("sb_direct", mem[8], 32'h11553344);
      issue(OP_SH, 32'h20, 32'h0000ABCD);
      idle_cycle();
      chk("sh_direct", mem[8], 32'h1155ABCD);
      check_word(32'h20);

      // Faults
      issue(OP_LW, 32'h13, 32'h0);
      chk("mis_addr_direct", exc_addr, 32'h13);
      idle_cycle();
      issue(OP_LB, 32'h1000, 32'h0);
      chk("rng_addr_direct", exc_addr, 32'h1000);
      idle_cycle();
      issue(OP_SW, 32'h1002, 32'h0);   // both faults: misalign wins
      idle_cycle();

      // Store byte followed immediately by a load held through the stall
      issue(OP_SB, 32'h30, 32'h000000E7);
      issue(OP_LW, 32'h30, 32'h0);
      chk("sb_lw_merged", ld_data, ref_mem[12]);
      idle_cycle();

      // Reset in the middle of a write cycle drops the write
      issue(OP_SW, 32'h40, 32'hCAFEF00D);
      issue(OP_LW, 32'h40, 32'h0);
      issue(OP_SB, 32'h41, 32'h00000077);
      rst_n = 1'b0;
      #1;
      chk("rwr_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("rwr_stall", 32'(stall), 32'd0);
      chk("rwr_ce", 32'(mem_ce), 32'd0);
      chk("rwr_ld_data", ld_data, 32'h0);
      chk("rwr_exc_addr", exc_addr, 32'h0);
      chk("rwr_ld_valid", 32'(ld_valid), 32'd0);
      pend = 1'b0; exp_ld_data = 32'h0; exp_exc_addr = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rwr_word", mem[16], 32'hCAFEF00D);
      check_word(32'h40);

      // Randomized ops against the reference model
      for (int i = 0; i < 300; i++) begin
         r_op = 4'($urandom_range(0, 10));
         if ($urandom_range(0, 9) == 0)
            r_addr = {8'($urandom_range(0, 255)), 12'h0, 12'($urandom_range(0, 4095))};
         else
            r_addr = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) idle_cycle();
         else issue(r_op, r_addr, $urandom);
      end
      idle_cycle();
      for (int i = 0; i < 64; i++) check_word(32'(i * 4));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store controller; sits between the EX/MEM pipeline register and the word-wide data memory.
- Translates word, half and byte loads/stores into word-only memory accesses (ce/we/addr/wdata), extracts and sign/zero-extends load data, and flags misaligned or out-of-range addresses.
- Sub-word stores use a 2-cycle read-modify-write with a one-cycle pipeline stall.

Parameters:
- MEM_AW, 12, byte-address width backed by memory (1024 words); addr[31:MEM_AW] != 0 is out of range.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  EX/MEM holds a memory op this cycle
- req_op  in  4  operation code; see Decomposition
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data, right-aligned
- stall  out  1  upstream must hold its request; combinational, = (state==WR)
- mem_ce  out  1  memory enable to data memory
- mem_we  out  1  memory write strobe
- mem_addr  out  32  byte address to memory, bits[1:0] forced 0
- mem_wdata  out  32  full word to memory
- mem_rdata  in  32  combinational read word from memory
- ld_valid  out  1  registered; ld_data valid this cycle
- ld_data  out  32  registered extended load result
- exc_misalign  out  1  registered one-cycle pulse
- exc_range  out  1  registered one-cycle pulse
- exc_addr  out  32  registered faulting address; held until the next fault

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - ld_valid, ld_data, exc_misalign, exc_range and exc_addr = 0.
  - Combinational outputs with state=IDLE and no request: mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset during WR drops the pending write; no memory write occurs.
- Byte lanes are little-endian: byte k = bits[8k+7:8k], half h = bits[16h+15:16h].
- Alignment: LW/SW need addr[1:0]==0; LH/LHU/SH need addr[0]==0; byte ops are always aligned.
- Faults:
  - A misaligned or out-of-range request drives no memory access (mem_ce=0).
  - The next edge pulses the matching exception and loads exc_addr=req_addr; ld_valid stays 0.
  - Misalign takes priority if both faults apply.
- States: IDLE, WR.
- IDLE, req_valid=1, legal op:
  - Load: mem_ce=1, mem_we=0, mem_addr=addr&~3. Next edge: ld_data=extract(mem_rdata, op, addr[1:0]), ld_valid=1. Latency 1.
  - SW: mem_ce=1, mem_we=1, mem_wdata=req_wdata; written at the edge. No stall.
  - SB/SH:
    - Same cycle: mem_ce=1, mem_we=0 (read).
    - At the edge: capture merged word = mem_rdata with the addressed lane replaced by req_wdata[7:0] or [15:0]; capture the word address; state->WR.
- WR:
  - stall=1, mem_ce=1, mem_we=1, mem_addr=captured address, mem_wdata=merged word.
  - Next edge: state->IDLE.
  - req_* is ignored in WR; upstream re-presents it in the next IDLE cycle.
- NOP, or req_valid=0: mem_ce=0; ld_valid=0 next cycle.
- ld_valid is a one-cycle pulse per load. ld_data holds its value until the next load completes.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.

Decomposition:
- Shared define file holds:
  - Op codes: OP_NOP=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8; other codes are treated as NOP.
  - Existing RamEnable/RamWrite constants, reused for mem_ce/mem_we.
- One combinational sub-module, lsu_byte_lane, contains both lane functions:
  - Load extraction and extension.
  - Store merge.

Test Plan:
- SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> mem_we=1 in cycle 0; next load gives ld_valid=1, ld_data=0xDEADBEEF one cycle after the request.
- Memory word 0x10=0x8899AABB:
  - LB 0x11 -> 0xFFFFFFAA.
  - LBU 0x11 -> 0x000000AA.
  - LH 0x12 -> 0xFFFF8899.
  - LHU 0x12 -> 0x00008899.
- Memory word 0x20=0x11223344:
  - SB 0x22 data=0x55 -> stall=1 for exactly one cycle (WR); memory then holds 0x11553344.
  - SH 0x20 data=0xABCD -> memory holds 0x1155ABCD.
- LW 0x13 -> mem_ce=0; exc_misalign pulse; exc_addr=0x13; no ld_valid. LB 0x1000 (MEM_AW=12) -> exc_range pulse; exc_addr=0x1000.
- SB 0x30 followed by back-to-back LW 0x30:
  - LW held during the stall cycle.
  - Completes afterwards and returns the merged word.
- Assert rst_n=0 during WR of SB 0x40 -> memory word unchanged, state IDLE, all registered outputs 0 immediately (async).
